// File: rtl/spike_hit_controller.sv
// rtl/spike_hit_controller.sv - per-frame player/spike collision, lives and invulnerability control
module spike_hit_controller #(
  parameter int LIVES_INIT    = 3,
  parameter int LIVES_W       = 2,
  parameter int INVULN_FRAMES = 90,
  parameter int BLINK_LOG2    = 3
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               game_on,
  input  logic               player_draw,
  input  logic               spikes_draw,
  output logic               hit_pulse,
  output logic               invuln,
  output logic               player_blink,
  output logic [LIVES_W-1:0] lives,
  output logic               player_dead
);

  localparam int                 CNT_W      = $clog2(INVULN_FRAMES + 1);
  localparam logic [CNT_W-1:0]   INV_LOAD   = CNT_W'(INVULN_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
  localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } state_t;

  state_t             state_q;
  logic               col_seen_q;
  logic               col_seen_d;
  logic [CNT_W-1:0]   inv_cnt_q;
  logic [CNT_W-1:0]   inv_cnt_dec;
  logic [LIVES_W-1:0] lives_q;
  logic               hit_pulse_q;
  logic               invuln_q;
  logic               blink_q;
  logic               dead_q;
  logic               overlap;

  assign overlap     = game_on & player_draw & spikes_draw;
  assign inv_cnt_dec = inv_cnt_q - CNT_ONE;

  // Frame collision accumulator; the sof pixel already belongs to the next frame.
  always_comb begin
    col_seen_d = col_seen_q;
    if (!game_on || state_q == IDLE) begin
      col_seen_d = 1'b0;
    end else if (startOfFrame) begin
      col_seen_d = overlap;
    end else begin
      col_seen_d = col_seen_q | overlap;
    end
  end

  // Collision flag register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      col_seen_q <= 1'b0;
    end else begin
      col_seen_q <= col_seen_d;
    end
  end

  // Game FSM with registered outputs; decisions only on sof, except leaving the game.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      lives_q     <= LIVES_LOAD;
      inv_cnt_q   <= '0;
      hit_pulse_q <= 1'b0;
      invuln_q    <= 1'b0;
      blink_q     <= 1'b0;
      dead_q      <= 1'b0;
    end else begin
      hit_pulse_q <= 1'b0;
      if (!game_on) begin
        state_q   <= IDLE;
        lives_q   <= LIVES_LOAD;
        inv_cnt_q <= '0;
        invuln_q  <= 1'b0;
        blink_q   <= 1'b0;
        dead_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= ARMED;
          end
          ARMED: begin
            if (startOfFrame && col_seen_q) begin
              hit_pulse_q <= 1'b1;
              if (lives_q <= LIVES_ONE) begin
                lives_q <= '0;
                dead_q  <= 1'b1;
                state_q <= DEAD;
              end else begin
                lives_q   <= lives_q - LIVES_ONE;
                inv_cnt_q <= INV_LOAD;
                invuln_q  <= 1'b1;
                blink_q   <= INV_LOAD[BLINK_LOG2];
                state_q   <= INVULN;
              end
            end
          end
          INVULN: begin
            if (startOfFrame) begin
              if (inv_cnt_q <= CNT_ONE) begin
                // Counter saturates at zero; the window closes on this sof.
                inv_cnt_q <= '0;
                invuln_q  <= 1'b0;
                blink_q   <= 1'b0;
                state_q   <= ARMED;
              end else begin
                inv_cnt_q <= inv_cnt_dec;
                blink_q   <= inv_cnt_dec[BLINK_LOG2];
              end
            end
          end
          DEAD: begin
            lives_q <= '0;
            dead_q  <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign hit_pulse    = hit_pulse_q;
  assign invuln       = invuln_q;
  assign player_blink = blink_q;
  assign lives        = lives_q;
  assign player_dead  = dead_q;

endmodule
